// File: rtl/cprv_pkg.sv
// cprv_pkg: shared constants and types for the writeback stage
package cprv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 64;

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [XLEN-1:0]       rd_data;
    } wb_req_t;
endpackage

// File: rtl/cprv_scoreboard.sv
// cprv_scoreboard: busy bits for registers awaiting a long-latency writeback
module cprv_scoreboard
    import cprv_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy_hit,
    output logic [NUM_REGS-1:0]   busy
);
    logic [NUM_REGS-1:0] busy_nxt;

    // set is applied after clear so a same-cycle set wins; x0 never becomes busy
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_en && clr_addr == REG_ADDR_W'(i)) busy_nxt[i] = 1'b0;
            if (set_en && set_addr == REG_ADDR_W'(i)) busy_nxt[i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign busy_hit = busy[rs1_addr] | busy[rs2_addr] | busy[rd_addr];
endmodule

// File: rtl/cprv_rf_wb_arbiter.sv
// cprv_rf_wb_arbiter: round-robin share of the regfile write port between
// the pipeline and the long-latency unit, plus issue hazard generation
module cprv_rf_wb_arbiter
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid_i,
    output logic                  p0_ready_o,
    input  logic [4:0]            p0_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_rd_data_i,
    input  logic                  p1_valid_i,
    output logic                  p1_ready_o,
    input  logic [4:0]            p1_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_rd_data_i,
    input  logic                  sb_set_en_i,
    input  logic [4:0]            sb_set_addr_i,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    input  logic [4:0]            rd_addr_i,
    output logic                  hazard_o,
    output logic                  rf_rd_en_o,
    output logic [4:0]            rf_rd_addr_o,
    output logic [DATA_WIDTH-1:0] rf_rd_data_o,
    output logic [NUM_REGS-1:0]   sb_busy_o
);
    logic                  last_grant;
    logic                  xfer;
    logic                  sb_hit;
    logic [4:0]            win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // last_grant names the port served last; the other one wins a tie
    assign p0_ready_o = p0_valid_i & (~p1_valid_i | last_grant);
    assign p1_ready_o = p1_valid_i & (~p0_valid_i | ~last_grant);
    assign xfer       = p0_ready_o | p1_ready_o;
    assign win_addr   = p1_ready_o ? p1_rd_addr_i : p0_rd_addr_i;
    assign win_data   = p1_ready_o ? p1_rd_data_i : p0_rd_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            rf_rd_en_o   <= 1'b0;
            rf_rd_addr_o <= '0;
            rf_rd_data_o <= '0;
        end else begin
            rf_rd_en_o <= xfer && win_addr != 5'd0;
            if (xfer) begin
                last_grant   <= p1_ready_o;
                rf_rd_addr_o <= win_addr;
                rf_rd_data_o <= win_data;
            end
        end
    end

    cprv_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set_en_i),
        .set_addr (sb_set_addr_i),
        .clr_en   (p1_ready_o),
        .clr_addr (p1_rd_addr_i),
        .rs1_addr (rs1_addr_i),
        .rs2_addr (rs2_addr_i),
        .rd_addr  (rd_addr_i),
        .busy_hit (sb_hit),
        .busy     (sb_busy_o)
    );

    // no forwarding: a source matching the write still in the output register must wait
    assign hazard_o = sb_hit | (rf_rd_en_o & (rf_rd_addr_o == rs1_addr_i | rf_rd_addr_o == rs2_addr_i));
endmodule
